// File: rtl/suma_serial.sv
// Bit-serial 4-bit adder: one full-adder step per clock, LSB first, with registered sum and flags.
// Optional carry-in port enabled by defining SUMA_SERIAL_CIN_EN.
module suma_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
`ifdef SUMA_SERIAL_CIN_EN
    input  logic       Cin,
`endif
    output logic       busy,
    output logic       done,
    output logic [3:0] S,
    output logic       Z,
    output logic       N,
    output logic       C,
    output logic       V
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] s_q, s_d;
    logic       z_q, z_d;
    logic       n_q, n_d;
    logic       c_q, c_d;
    logic       v_q, v_d;

    logic       cin_init;
    logic       sum_bit;
    logic       cout;

`ifdef SUMA_SERIAL_CIN_EN
    assign cin_init = Cin;
`else
    assign cin_init = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    // Full adder on the current bit of the latched operands.
    assign sum_bit = a_q[idx_q] ^ b_q[idx_q] ^ carry_q;
    assign cout    = (a_q[idx_q] & b_q[idx_q]) | (carry_q & (a_q[idx_q] ^ b_q[idx_q]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin_init;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d[idx_q] = sum_bit;
                carry_d      = cout;
                idx_d        = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // Visible results change only here; carry_q is the carry into bit 3.
                    state_d = DONE;
                    s_d     = {sum_bit, acc_q[2:0]};
                    z_d     = ({sum_bit, acc_q[2:0]} == 4'd0);
                    n_d     = sum_bit;
                    c_d     = cout;
                    v_d     = carry_q ^ cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign S = s_q;
    assign Z = z_q;
    assign N = n_q;
    assign C = c_q;
    assign V = v_q;

endmodule

// File: tb/tb_suma_serial.sv
// Scoreboard bench for suma_serial: accepted operations are queued, results checked when done rises.
// Define SUMA_SERIAL_CIN_EN to exercise the carry-in port.
module tb_suma_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
`ifdef SUMA_SERIAL_CIN_EN
    logic       Cin;
`endif
    logic       busy;
    logic       done;
    logic [3:0] S;
    logic       Z;
    logic       N;
    logic       C;
    logic       V;

    suma_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SUMA_SERIAL_CIN_EN
        .Cin   (Cin),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Z     (Z),
        .N     (N),
        .C     (C),
        .V     (V)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        int         cyc;
    } op_t;

    op_t q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  model_cnt = 0;
    logic model_done = 1'b0;
    logic prev_done  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference acceptance model: start taken only when no operation is in flight.
    always @(posedge clk or posedge rst) begin
        op_t e;
        if (rst) begin
            q.delete();
            model_cnt  = 0;
            model_done = 1'b0;
        end else begin
            cyc++;
            if (model_cnt == 0 && start) begin
                e.a = A;
                e.b = B;
`ifdef SUMA_SERIAL_CIN_EN
                e.cin = Cin;
`else
                e.cin = 1'b0;
`endif
                e.cyc = cyc;
                q.push_back(e);
                model_cnt  = 4;
                model_done = 1'b0;
            end else if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) model_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        op_t        e;
        logic [4:0] full;
        logic [3:0] low;
        logic [7:0] exp_res;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            check("status", {30'd0, busy, done}, {30'd0, (model_cnt > 0), model_done});
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    check("spurious_done", q.size(), 1);
                end else begin
                    e    = q.pop_front();
                    full = {1'b0, e.a} + {1'b0, e.b} + {4'd0, e.cin};
                    low  = {1'b0, e.a[2:0]} + {1'b0, e.b[2:0]} + {3'd0, e.cin};
                    exp_res = {full[3:0], (full[3:0] == 4'd0), full[3], full[4], low[3] ^ full[4]};
                    check("result", {24'd0, S, Z, N, C, V}, {24'd0, exp_res});
                    check("latency", cyc - e.cyc, 4);
                end
            end
            prev_done = done;
        end
    end

    task automatic drain();
        int t = 0;
        while ((q.size() > 0 || model_cnt > 0) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", (t >= 40) ? 1 : 0, 0);
        @(negedge clk);
    endtask

    task automatic op(input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #2;
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #2;
        start = 1'b0;
        // Operands flip mid-operation; the latched copy must be used.
        A = ~a;
        B = ~b;
        drain();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef SUMA_SERIAL_CIN_EN
        Cin   = 1'b0;
`endif
        #1;
        check("reset_out", {22'd0, S, Z, N, C, V, busy, done}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        op(4'b0011, 4'b0010);
        op(4'b0101, 4'b0011);
        op(4'b1000, 4'b1000);
        op(4'b1111, 4'b0001);
        op(4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Continuous start with operands changing every cycle.
        @(posedge clk);
        #2 start = 1'b1;
        for (int i = 0; i < 22; i++) begin
            A = 4'($urandom_range(0, 15));
            B = 4'($urandom_range(0, 15));
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        drain();

        // Abort two cycles into SHIFT, then restart on the first free edge.
        @(posedge clk);
        #2;
        start = 1'b1;
        A     = 4'b0110;
        B     = 4'b0111;
        @(posedge clk);
        #2 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out", {22'd0, S, Z, N, C, V, busy, done}, 0);
        @(posedge clk);
        #2;
        start = 1'b1;
        A     = 4'b1001;
        B     = 4'b0100;
        rst   = 1'b0;
        @(posedge clk);
        #2 start = 1'b0;
        drain();

`ifdef SUMA_SERIAL_CIN_EN
        Cin = 1'b1;
        op(4'b0111, 4'b0000);
        Cin = 1'b0;
        op(4'b0111, 4'b0000);
        Cin = 1'b1;
        op(4'b1111, 4'b1111);
        Cin = 1'b0;
`else
        op(4'b0111, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
